// File: rtl/mult_64x64_pipe_pkg.sv
// Shared constants and types for the 64x64 pipelined multiplier.
// Optional signed support is enabled by defining MULT64_SIGNED_EN.
package mult64_pkg;

   localparam int W_IN    = 64;
   localparam int W_HALF  = 32;
   localparam int W_OUT   = 128;
   localparam int LATENCY = 2;

   typedef logic [W_IN-1:0]     op64_t;
   typedef logic [W_OUT-1:0]    prod128_t;
   typedef logic [2*W_HALF-1:0] pp64_t;
   typedef logic [W_HALF-1:0]   half_t;

endpackage

// File: rtl/mult_64x64_pipe_if.sv
// Operand/product bus of the 64x64 multiplier; signed_op exists only
// when MULT64_SIGNED_EN is defined.
interface mult_64x64_pipe_if;
   import mult64_pkg::*;

   logic     in_valid;
   op64_t    a;
   op64_t    b;
   logic     out_valid;
   prod128_t p;
`ifdef MULT64_SIGNED_EN
   logic     signed_op;

   modport master (output in_valid, a, b, signed_op, input out_valid, p);
   modport slave  (input in_valid, a, b, signed_op, output out_valid, p);
`else
   modport master (output in_valid, a, b, input out_valid, p);
   modport slave  (input in_valid, a, b, output out_valid, p);
`endif

endinterface

// File: rtl/mult_64x64_pipe_mult_32x32.sv
// Combinational 32x32 unsigned multiplier with a full 64-bit result.
module mult_32x32
   import mult64_pkg::*;
(
   input  half_t x,
   input  half_t y,
   output pp64_t z
);

   assign z = {32'b0, x} * {32'b0, y};

endmodule

// File: rtl/mult_64x64_pipe.sv
// Pipelined 64x64 -> 128 multiplier: operand capture, four 32x32 partial
// products, then summation. Define MULT64_SIGNED_EN for two's-complement support.
module mult_64x64_pipe #(
   parameter int LATENCY = 2
) (
   input logic              clk,
   input logic              rst_n,
   mult_64x64_pipe_if.slave bus
);
   import mult64_pkg::*;

   if (LATENCY != mult64_pkg::LATENCY) begin : g_bad_latency
      $error("mult_64x64_pipe: LATENCY must be 2");
   end

   // capture stage
   logic  v0_q, v0_d;
   op64_t a0_q, a0_d, b0_q, b0_d;
   // partial-product stage
   logic  v1_q, v1_d;
   pp64_t ll_q, ll_d, lh_q, lh_d, hl_q, hl_d, hh_q, hh_d;
   pp64_t ll_w, lh_w, hl_w, hh_w;
   // output stage
   logic     v2_q, v2_d;
   prod128_t p_q, p_d;
   prod128_t sum;

`ifdef MULT64_SIGNED_EN
   logic  s0_q, s0_d, s1_q, s1_d;
   op64_t a1_q, a1_d, b1_q, b1_d;
`endif

   mult_32x32 u_ll (.x(a0_q[31:0]),  .y(b0_q[31:0]),  .z(ll_w));
   mult_32x32 u_lh (.x(a0_q[31:0]),  .y(b0_q[63:32]), .z(lh_w));
   mult_32x32 u_hl (.x(a0_q[63:32]), .y(b0_q[31:0]),  .z(hl_w));
   mult_32x32 u_hh (.x(a0_q[63:32]), .y(b0_q[63:32]), .z(hh_w));

   always_comb begin
      // NOTE: every _d gets a hold/default value up front so no path leaves it unassigned (no latches).
      v0_d = bus.in_valid;
      a0_d = bus.in_valid ? bus.a : a0_q;
      b0_d = bus.in_valid ? bus.b : b0_q;

      v1_d = v0_q;
      ll_d = v0_q ? ll_w : ll_q;
      lh_d = v0_q ? lh_w : lh_q;
      hl_d = v0_q ? hl_w : hl_q;
      hh_d = v0_q ? hh_w : hh_q;

      sum = {hh_q, ll_q} + {32'b0, lh_q, 32'b0} + {32'b0, hl_q, 32'b0};
`ifdef MULT64_SIGNED_EN
      s0_d = bus.in_valid ? bus.signed_op : s0_q;
      s1_d = v0_q ? s0_q : s1_q;
      a1_d = v0_q ? a0_q : a1_q;
      b1_d = v0_q ? b0_q : b1_q;
      // Two's-complement correction of the unsigned product, modulo 2^128.
      if (s1_q && a1_q[63]) sum = sum - {b1_q, 64'b0};
      if (s1_q && b1_q[63]) sum = sum - {a1_q, 64'b0};
`endif

      v2_d = v1_q;
      p_d  = v1_q ? sum : p_q;
   end

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: data registers are cleared too, so p is defined (zero) straight out of reset.
         v0_q <= 1'b0;
         a0_q <= '0;
         b0_q <= '0;
         v1_q <= 1'b0;
         ll_q <= '0;
         lh_q <= '0;
         hl_q <= '0;
         hh_q <= '0;
         v2_q <= 1'b0;
         p_q  <= '0;
`ifdef MULT64_SIGNED_EN
         s0_q <= 1'b0;
         s1_q <= 1'b0;
         a1_q <= '0;
         b1_q <= '0;
`endif
      end else begin
         v0_q <= v0_d;
         a0_q <= a0_d;
         b0_q <= b0_d;
         v1_q <= v1_d;
         ll_q <= ll_d;
         lh_q <= lh_d;
         hl_q <= hl_d;
         hh_q <= hh_d;
         v2_q <= v2_d;
         p_q  <= p_d;
`ifdef MULT64_SIGNED_EN
         s0_q <= s0_d;
         s1_q <= s1_d;
         a1_q <= a1_d;
         b1_q <= b1_d;
`endif
      end
   end

   assign bus.out_valid = v2_q;
   assign bus.p         = p_q;

endmodule

// File: tb/tb_mult_64x64_pipe.sv
// Self-checking bench for mult_64x64_pipe: plain-arithmetic reference model,
// per-cycle compare, plus hand-computed directed expectations.
module tb_mult_64x64_pipe;
   import mult64_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic sop;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   mult_64x64_pipe_if bus ();

   mult_64x64_pipe #(.LATENCY(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef MULT64_SIGNED_EN
   assign bus.signed_op = sop;
`endif

   always #5 clk = ~clk;

   task automatic check(input string name, input prod128_t act, input prod128_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%032h expected 0x%032h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic prod128_t ref_mul(input op64_t x, input op64_t y, input logic s);
      prod128_t xe, ye;
      xe = s ? {{64{x[63]}}, x} : {64'b0, x};
      ye = s ? {{64{y[63]}}, y} : {64'b0, y};
      return xe * ye;
   endfunction

   // Reference: results emerge two edges after the sampling edge; p holds otherwise.
   bit       m_v [2];
   prod128_t m_p [2];
   bit       m_ov;
   prod128_t m_hold;
   logic     m_sop;

   always @(posedge clk) begin
`ifdef MULT64_SIGNED_EN
      m_sop = sop;
`else
      m_sop = 1'b0;
`endif
      if (!rst_n) begin
         m_v    = '{1'b0, 1'b0};
         m_p    = '{128'b0, 128'b0};
         m_ov   = 1'b0;
         m_hold = '0;
      end else begin
         m_ov = m_v[1];
         if (m_v[1]) m_hold = m_p[1];
         m_v[1] = m_v[0];
         m_p[1] = m_p[0];
         m_v[0] = bus.in_valid;
         m_p[0] = ref_mul(bus.a, bus.b, m_sop);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model out_valid", {127'b0, bus.out_valid}, {127'b0, m_ov});
         check("model p", bus.p, m_hold);
      end
   end

   task automatic drive(input logic v, input op64_t x, input op64_t y, input logic s);
      @(negedge clk);
      bus.in_valid = v;
      bus.a        = x;
      bus.b        = y;
      sop          = s;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, bus.a, bus.b, sop);
   endtask

   // Single op: out_valid must be low one cycle early and high exactly on time.
   task automatic run_op(input string name, input op64_t x, input op64_t y,
                         input logic s, input prod128_t exp);
      drive(1'b1, x, y, s);
      drive(1'b0, x, y, s);
      @(negedge clk);
      check({name, " early out_valid"}, {127'b0, bus.out_valid}, 128'd0);
      @(negedge clk);
      check({name, " out_valid"}, {127'b0, bus.out_valid}, 128'd1);
      check({name, " p"}, bus.p, exp);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      sop          = 1'b0;
      @(posedge clk);
      chk_en = 1'b1;
      idle(2);
      check("reset out_valid", {127'b0, bus.out_valid}, 128'd0);
      check("reset p", bus.p, 128'd0);
      rst_n = 1'b1;
      idle(2);

      run_op("basic", 64'h11, 64'h111, 1'b0, 128'h1221);
      run_op("cross", 64'h1_0000_0001, 64'h1_0000_0001, 1'b0,
             128'h0000_0000_0000_0001_0000_0002_0000_0001);
      run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
      run_op("carry", 64'h1_0000_0000, 64'h1_0000_0000, 1'b0,
             128'h1_0000_0000_0000_0000);
      run_op("neg1x2 unsigned", 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0,
             128'h1_FFFF_FFFF_FFFF_FFFE);
      idle(3);

      // Streaming with a bubble, then back-to-back valids.
      drive(1'b1, 64'hABCDE12345678911, 64'h01479230BFA1203D, 1'b0);
      drive(1'b0, 64'h0, 64'h0, 1'b0);
      drive(1'b1, 64'h0A00A0349182CFBB, 64'h01001DDAB0298485, 1'b0);
      drive(1'b1, 64'hDEAD_BEEF_0123_4567, 64'h8000_0000_0000_0001, 1'b0);
      drive(1'b1, 64'h0000_0001_FFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 1'b0);
      idle(4);

`ifdef MULT64_SIGNED_EN
      run_op("signed -1*-1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
             128'h1);
      run_op("signed -1*2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b1,
             128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
      run_op("unsigned op max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
      drive(1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
      drive(1'b1, 64'h1234_5678_9ABC_DEF0, 64'hF000_0000_0000_0003, 1'b1);
      drive(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      idle(4);
`endif

      // Reset with two valid ops in flight: neither may emerge.
      drive(1'b1, 64'h3, 64'h5, 1'b0);
      drive(1'b1, 64'h7, 64'h9, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      idle(2);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post-reset out_valid", {127'b0, bus.out_valid}, 128'd0);
         check("post-reset p", bus.p, 128'd0);
      end

      run_op("after reset", 64'h2, 64'h3, 1'b0, 128'h6);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
